// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, a two-entry skid buffer,
// a synchronous flush that inserts bubbles, and a saturating bubble counter.
module pipe_stage_reg #(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 138,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] w_main_ctrl_nxt;
  logic [CTRL_W-1:0] w_skid_ctrl_nxt;
  logic [DATA_W-1:0] w_main_data_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic              w_push;
  logic              w_pop;
  logic              w_bubble;

  // in_ready and out_valid come only from the state register, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (r_state != ST_FULL);
  assign out_valid = (r_state != ST_EMPTY);
  assign out_ctrl  = out_valid ? r_main_ctrl : {CTRL_W{1'b0}};
  assign out_data  = r_main_data;
  assign occupancy = r_state;
  assign bubble_cnt = r_bubble_cnt;

  assign w_push   = in_valid & in_ready;
  assign w_pop    = out_valid & out_ready;
  assign w_bubble = out_ready & ~out_valid;

  // Next-state and register-load selection; flush overrides any push or pop.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_ctrl_nxt = r_main_ctrl;
    w_main_data_nxt = r_main_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    w_skid_data_nxt = r_skid_data;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_state_nxt     = ST_ONE;
            w_main_ctrl_nxt = in_ctrl;
            w_main_data_nxt = in_data;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (w_push && w_pop) begin
            w_main_ctrl_nxt = in_ctrl;
            w_main_data_nxt = in_data;
          end else if (w_push) begin
            w_state_nxt     = ST_FULL;
            w_skid_ctrl_nxt = in_ctrl;
            w_skid_data_nxt = in_data;
          end else if (w_pop) begin
            w_state_nxt = ST_EMPTY;
          end else begin
            w_state_nxt = ST_ONE;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_state_nxt     = ST_ONE;
            w_main_ctrl_nxt = r_skid_ctrl;
            w_main_data_nxt = r_skid_data;
          end else begin
            w_state_nxt = ST_FULL;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_main_ctrl <= {CTRL_W{1'b0}};
      r_main_data <= {DATA_W{1'b0}};
      r_skid_ctrl <= {CTRL_W{1'b0}};
      r_skid_data <= {DATA_W{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_main_data <= w_main_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
    end
  end

  // Saturating count of cycles where downstream was ready but got nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= {CNT_W{1'b0}};
    end else if (w_bubble && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end else begin
      r_bubble_cnt <= r_bubble_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a queue model of held entries predicts
// outputs; a second instance with a 3-bit counter covers saturation.
module tb_pipe_stage_reg;
  localparam int CW = 10;
  localparam int DW = 138;
  typedef logic [CW+DW-1:0] ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   bubble_cnt;
  logic          d3_in_ready, d3_out_valid;
  logic [CW-1:0] d3_out_ctrl;
  logic [DW-1:0] d3_out_data;
  logic [1:0]    d3_occupancy;
  logic [2:0]    d3_bubble_cnt;

  ent_t        sb[$];
  logic [15:0] m_cnt16 = 16'd0;
  logic [2:0]  m_cnt3 = 3'd0;
  int          n_err = 0;
  int          n_chk = 0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d3_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(d3_out_valid),
    .out_ready(out_ready), .out_ctrl(d3_out_ctrl), .out_data(d3_out_data),
    .occupancy(d3_occupancy), .bubble_cnt(d3_bubble_cnt));

  always #5 clk = ~clk;

  // Advance one clock and update the model; the expected entry is queued on push.
  task automatic tick();
    logic push, pop, bub;
    push = in_valid && (sb.size() < 2);
    pop  = (sb.size() != 0) && out_ready;
    bub  = out_ready && (sb.size() == 0);
    @(posedge clk);
    if (bub) begin
      if (m_cnt16 != 16'hFFFF) m_cnt16 = m_cnt16 + 16'd1;
      if (m_cnt3 != 3'd7) m_cnt3 = m_cnt3 + 3'd1;
    end
    if (flush) sb.delete();
    else begin
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back({in_ctrl, in_data});
    end
    #1;
  endtask

  task automatic model_clear();
    sb.delete();
    m_cnt16 = 16'd0;
    m_cnt3 = 3'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || occupancy !== 2'd0 || bubble_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b c=%h d=%h occ=%0d cnt=%0d, want all 0", out_valid, out_ctrl, out_data, occupancy, bubble_cnt);
    end
    rst_n = 1'b1;
    model_clear();
    out_ready = 1'b1;
    repeat (5) tick();
    n_chk++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
      n_err++;
      $display("FAIL idle_state: got v=%b c=%h rdy=%b occ=%0d, want 0 0 1 0", out_valid, out_ctrl, in_ready, occupancy);
    end
    n_chk++;
    if (bubble_cnt !== 16'd5 || d3_bubble_cnt !== 3'd5) begin
      n_err++;
      $display("FAIL idle_bubbles: got %0d/%0d, want 5/5", bubble_cnt, d3_bubble_cnt);
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 10'h155;
    for (int i = 0; i < 4; i++) begin
      in_data = DW'(i + 1);
      n_chk++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL stream_ready[%0d]: got %b, want 1", i, in_ready);
      end
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || occupancy !== 2'd1 || out_ctrl !== 10'h155 || out_data !== DW'(i + 1)) begin
        n_err++;
        $display("FAIL stream_out[%0d]: got v=%b occ=%0d c=%h d=%h, want 1 1 155 %h", i, out_valid, occupancy, out_ctrl, out_data, i + 1);
      end
      n_chk++;
      if (sb.size() != 1 || {out_ctrl, out_data} !== sb[0]) begin
        n_err++;
        $display("FAIL stream_sb[%0d]: got %h, queue depth %0d", i, {out_ctrl, out_data}, sb.size());
      end
    end
    in_valid = 1'b0;
    tick();
    n_chk++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== DW'(4)) begin
      n_err++;
      $display("FAIL stream_drain: got v=%b c=%h d=%h, want 0 0 4", out_valid, out_ctrl, out_data);
    end
  endtask

  task automatic test_back_to_back();
    int   iv_t[7] = '{1, 1, 1, 1, 1, 0, 0};
    int   ds_t[7] = '{0, 1, 2, 2, 2, 0, 0};
    int   or_t[7] = '{1, 0, 0, 1, 1, 1, 1};
    ent_t vals[3];
    ent_t seen[$];
    for (int k = 0; k < 3; k++) vals[k] = {CW'(k + 256), DW'(k + 40960)};
    for (int c = 0; c < 7; c++) begin
      in_valid = (iv_t[c] != 0);
      {in_ctrl, in_data} = vals[ds_t[c]];
      out_ready = (or_t[c] != 0);
      n_chk++;
      if (occupancy !== 2'(sb.size()) || in_ready !== (sb.size() < 2) || out_valid !== (sb.size() != 0)) begin
        n_err++;
        $display("FAIL bp_state[%0d]: got occ=%0d rdy=%b v=%b, want occ=%0d", c, occupancy, in_ready, out_valid, sb.size());
      end
      if (sb.size() != 0) begin
        n_chk++;
        if ({out_ctrl, out_data} !== sb[0]) begin
          n_err++;
          $display("FAIL bp_data[%0d]: got %h, want %h", c, {out_ctrl, out_data}, sb[0]);
        end
      end
      if (c == 2) begin
        n_chk++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL bp_full: got occ=%0d rdy=%b, want 2 0", occupancy, in_ready);
        end
      end
      if (out_valid && out_ready) seen.push_back({out_ctrl, out_data});
      tick();
    end
    n_chk++;
    if (seen.size() != 3 || seen[0] !== vals[0] || seen[1] !== vals[1] || seen[2] !== vals[2]) begin
      n_err++;
      $display("FAIL bp_order: got %0d entries, want A,B,C in order", seen.size());
    end
  endtask

  task automatic test_flush();
    logic [15:0] b0;
    out_ready = 1'b0; in_valid = 1'b1;
    in_ctrl = 10'h0A1; in_data = DW'(32'hAAAA); tick();
    in_ctrl = 10'h0B2; in_data = DW'(32'hBBBB); tick();
    n_chk++;
    if (occupancy !== 2'd2) begin
      n_err++;
      $display("FAIL flush_pre: got occ=%0d, want 2", occupancy);
    end
    b0 = m_cnt16;
    flush = 1'b1; in_ctrl = 10'h0C3; in_data = DW'(32'hCCCC);
    tick();
    flush = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_bubble: got v=%b c=%h occ=%0d rdy=%b, want 0 0 0 1", out_valid, out_ctrl, occupancy, in_ready);
    end
    n_chk++;
    if (out_data !== DW'(32'hAAAA) || bubble_cnt !== b0) begin
      n_err++;
      $display("FAIL flush_hold: got d=%h cnt=%0d, want d=aaaa cnt=%0d", out_data, bubble_cnt, b0);
    end
    in_ctrl = 10'h0D4; in_data = DW'(32'hDDDD); out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b1 || out_ctrl !== 10'h0D4 || out_data !== DW'(32'hDDDD) || occupancy !== 2'd1) begin
      n_err++;
      $display("FAIL flush_next: got v=%b c=%h d=%h occ=%0d, want 1 0d4 dddd 1", out_valid, out_ctrl, out_data, occupancy);
    end
    n_chk++;
    if (bubble_cnt !== m_cnt16) begin
      n_err++;
      $display("FAIL flush_cnt: got %0d, want %0d", bubble_cnt, m_cnt16);
    end
    tick();
  endtask

  task automatic test_push_pop_one();
    out_ready = 1'b0; in_valid = 1'b1;
    in_ctrl = 10'h011; in_data = DW'(32'h1111); tick();
    n_chk++;
    if (occupancy !== 2'd1 || out_data !== DW'(32'h1111) || out_ctrl !== 10'h011) begin
      n_err++;
      $display("FAIL pp_hold: got occ=%0d c=%h d=%h, want 1 011 1111", occupancy, out_ctrl, out_data);
    end
    in_ctrl = 10'h022; in_data = DW'(32'h2222); out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_chk++;
    if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_ctrl !== 10'h022 || out_data !== DW'(32'h2222)) begin
      n_err++;
      $display("FAIL pp_swap: got occ=%0d rdy=%b c=%h d=%h, want 1 1 022 2222", occupancy, in_ready, out_ctrl, out_data);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_err++;
      $display("FAIL pp_drain: got v=%b occ=%0d, want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_saturation();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    out_ready = 1'b1;
    repeat (10) tick();
    n_chk++;
    if (d3_bubble_cnt !== 3'd7 || bubble_cnt !== 16'd10) begin
      n_err++;
      $display("FAIL sat_cnt: got %0d/%0d, want 7/10", d3_bubble_cnt, bubble_cnt);
    end
    repeat (3) tick();
    n_chk++;
    if (d3_bubble_cnt !== m_cnt3 || d3_bubble_cnt !== 3'd7 || bubble_cnt !== m_cnt16) begin
      n_err++;
      $display("FAIL sat_hold: got %0d/%0d, want 7/%0d", d3_bubble_cnt, bubble_cnt, m_cnt16);
    end
    in_valid = 1'b1; in_ctrl = 10'h3E5; in_data = DW'(32'hEEEE);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b1 || d3_out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL sat_held: got %b/%b, want 1/1", out_valid, d3_out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0 || occupancy !== 2'd0) begin
      n_err++;
      $display("FAIL async_rst: got v=%b c=%h d=%h occ=%0d, want all 0", out_valid, out_ctrl, out_data, occupancy);
    end
    n_chk++;
    if (bubble_cnt !== 16'd0 || d3_bubble_cnt !== 3'd0 || d3_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_rst_cnt: got %0d/%0d v3=%b, want 0/0 0", bubble_cnt, d3_bubble_cnt, d3_out_valid);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_to_back();
    test_flush();
    test_push_pop_one();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
